// File: rtl/etai_pipe_adder_if.sv
// Operand/result handshake bundle for etai_pipe_adder.
//   master : operand source plus result sink. Drives in_valid, x, y, k_sel, exact_en and out_ready.
//   slave  : the adder. Drives in_ready, out_valid, s, cout and err_mag.
//   KW     : width of k_sel, sized to hold 0..K_MAX.
interface etai_pipe_adder_if #(
    parameter int N     = 16,
    parameter int K_MAX = 12
);
    localparam int KW = $clog2(K_MAX + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  x;
    logic [N-1:0]  y;
    logic [KW-1:0] k_sel;
    logic          exact_en;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  s;
    logic          cout;
    logic [N:0]    err_mag;

    modport master (
        output in_valid, x, y, k_sel, exact_en, out_ready,
        input  in_ready, out_valid, s, cout, err_mag
    );

    modport slave (
        input  in_valid, x, y, k_sel, exact_en, out_ready,
        output in_ready, out_valid, s, cout, err_mag
    );
endinterface

// File: rtl/etai_pipe_adder.sv
// Two-stage pipelined Error Tolerant Adder type I with a runtime-selectable approximate width.
// Stage 1 registers the operands and the effective approximate width. Stage 2 registers the
// approximate sum, the upper-part carry and the absolute error against the exact sum.
// A statistics block counts result handshakes, counts erroneous results and tracks the largest error.
// Ports:
//   clk, rst  : rising-edge clock and synchronous active-high reset
//   bus       : operand/result valid-ready handshake bundle (slave side)
//   stats_clr : synchronous clear of the statistics. It takes priority over a same-cycle result handshake.
//   op_cnt    : number of completed result beats, saturating
//   err_cnt   : number of completed result beats with a non-zero error, saturating
//   max_err   : largest err_mag seen among completed result beats
module etai_pipe_adder #(
    parameter int N     = 16,
    parameter int K_MAX = 12,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    etai_pipe_adder_if.slave      bus,
    input  logic                  stats_clr,
    output logic [CW-1:0]         op_cnt,
    output logic [CW-1:0]         err_cnt,
    output logic [N:0]            max_err
);
    localparam int              KW      = $clog2(K_MAX + 1);
    localparam logic [KW-1:0]   K_MAX_W = KW'(K_MAX);
    localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_MAX = {CW{1'b1}};

    // ETA-I sum in {cout, s} form.
    // The upper part is an exact add with the low k bits masked off, so no carry crosses into it.
    // In the low part, the highest position where both bits are 1 saturates itself and every lower bit to 1.
    // Positions above that point take the XOR of the two operand bits.
    function automatic logic [N:0] eta_add(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic [KW-1:0] k);
        logic [N-1:0] lo_mask;
        logic [N-1:0] lo;
        logic         found;
        logic [N:0]   up;
        lo_mask = {N{1'b0}};
        lo      = {N{1'b0}};
        found   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i < int'(k)) begin
                lo_mask[i] = 1'b1;
                if (a[i] & b[i]) begin
                    found = 1'b1;
                end else begin
                    found = found;
                end
                lo[i] = found | (a[i] ^ b[i]);
            end else begin
                lo[i] = 1'b0;
            end
        end
        up = {1'b0, a & ~lo_mask} + {1'b0, b & ~lo_mask};
        return up | {1'b0, lo};
    endfunction

    // Absolute difference of two N+1-bit values. The result always fits in N+1 bits.
    function automatic logic [N:0] abs_diff(input logic [N:0] a, input logic [N:0] b);
        logic [N:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    logic          adv1_s;
    logic          adv2_s;
    logic          out_hs_s;
    logic [KW-1:0] k_eff_s;
    logic [N:0]    approx_s;
    logic [N:0]    exact_s;
    logic [N:0]    diff_s;

    logic          s1_valid_r;
    logic [N-1:0]  s1_x_r;
    logic [N-1:0]  s1_y_r;
    logic [KW-1:0] s1_k_r;

    logic          out_valid_r;
    logic [N-1:0]  s_r;
    logic          cout_r;
    logic [N:0]    err_mag_r;

    logic [CW-1:0] op_cnt_r;
    logic [CW-1:0] err_cnt_r;
    logic [N:0]    max_err_r;

    // Pipeline advance conditions. in_ready depends combinationally on out_ready, which allows full throughput.
    always_comb begin
        adv2_s   = !out_valid_r || bus.out_ready;
        adv1_s   = !s1_valid_r || adv2_s;
        out_hs_s = out_valid_r && bus.out_ready;
    end

    // Effective approximate width. exact_en forces 0, and oversize selections clamp to K_MAX.
    always_comb begin
        k_eff_s = {KW{1'b0}};
        if (bus.exact_en) begin
            k_eff_s = {KW{1'b0}};
        end else if (bus.k_sel > K_MAX_W) begin
            k_eff_s = K_MAX_W;
        end else begin
            k_eff_s = bus.k_sel;
        end
    end

    // Stage 2 datapath: approximate sum, exact reference sum and their absolute difference.
    always_comb begin
        approx_s = eta_add(s1_x_r, s1_y_r, s1_k_r);
        exact_s  = {1'b0, s1_x_r} + {1'b0, s1_y_r};
        diff_s   = abs_diff(exact_s, approx_s);
    end

    // Stage 1 register. exact_en is folded into the registered k, because k=0 already means an exact add.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= {N{1'b0}};
            s1_y_r     <= {N{1'b0}};
            s1_k_r     <= {KW{1'b0}};
        end else if (adv1_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_x_r <= bus.x;
                s1_y_r <= bus.y;
                s1_k_r <= k_eff_s;
            end else begin
                s1_x_r <= s1_x_r;
                s1_y_r <= s1_y_r;
                s1_k_r <= s1_k_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2 register. The result fields only load with a new beat, so they hold stable during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            s_r         <= {N{1'b0}};
            cout_r      <= 1'b0;
            err_mag_r   <= {(N+1){1'b0}};
        end else if (adv2_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s_r       <= approx_s[N-1:0];
                cout_r    <= approx_s[N];
                err_mag_r <= diff_s;
            end else begin
                s_r       <= s_r;
                cout_r    <= cout_r;
                err_mag_r <= err_mag_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Result statistics. A clear in the same cycle as a handshake wins, so that beat is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_r  <= {CW{1'b0}};
            err_cnt_r <= {CW{1'b0}};
            max_err_r <= {(N+1){1'b0}};
        end else if (stats_clr) begin
            op_cnt_r  <= {CW{1'b0}};
            err_cnt_r <= {CW{1'b0}};
            max_err_r <= {(N+1){1'b0}};
        end else if (out_hs_s) begin
            if (op_cnt_r != CNT_MAX) begin
                op_cnt_r <= op_cnt_r + CNT_ONE;
            end else begin
                op_cnt_r <= op_cnt_r;
            end
            if ((err_mag_r != {(N+1){1'b0}}) && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
            if (err_mag_r > max_err_r) begin
                max_err_r <= err_mag_r;
            end else begin
                max_err_r <= max_err_r;
            end
        end else begin
            op_cnt_r  <= op_cnt_r;
            err_cnt_r <= err_cnt_r;
            max_err_r <= max_err_r;
        end
    end

    assign bus.in_ready  = adv1_s;
    assign bus.out_valid = out_valid_r;
    assign bus.s         = s_r;
    assign bus.cout      = cout_r;
    assign bus.err_mag   = err_mag_r;
    assign op_cnt        = op_cnt_r;
    assign err_cnt       = err_cnt_r;
    assign max_err       = max_err_r;
endmodule

// File: tb/tb_etai_pipe_adder.sv
// Self-checking bench for etai_pipe_adder: directed vectors, back-to-back stalls, randomized
// traffic against a behavioural ETA-I model with a result queue, statistics, and reset behaviour.
module tb_etai_pipe_adder;
    localparam int N     = 16;
    localparam int K_MAX = 12;
    localparam int CW    = 16;
    localparam int KW    = $clog2(K_MAX + 1);

    typedef struct {
        logic [N-1:0] s;
        logic         c;
        logic [N:0]   e;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          stats_clr;
    logic [CW-1:0] op_cnt;
    logic [CW-1:0] err_cnt;
    logic [N:0]    max_err;

    etai_pipe_adder_if #(.N(N), .K_MAX(K_MAX)) bus();

    etai_pipe_adder #(.N(N), .K_MAX(K_MAX), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stats_clr (stats_clr),
        .op_cnt    (op_cnt),
        .err_cnt   (err_cnt),
        .max_err   (max_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    res_t       exp_q[$];
    int         m_op;
    int         m_err;
    logic [N:0] m_max;

    // Reference ETA-I: exact add of the shifted-down upper parts, then the rule-based lower part.
    function automatic res_t ref_model(logic [N-1:0] a, logic [N-1:0] b, logic [KW-1:0] ksel, logic ex);
        res_t         r;
        int           k;
        int           pos;
        logic [N:0]   up;
        logic [N:0]   approx;
        logic [N:0]   exact;
        logic [N-1:0] lo;
        k = ex ? 0 : ((int'(ksel) > K_MAX) ? K_MAX : int'(ksel));
        up = ((({1'b0, a}) >> k) + (({1'b0, b}) >> k)) << k;
        pos = -1;
        for (int i = k - 1; i >= 0; i--) begin
            if (pos < 0 && a[i] && b[i]) pos = i;
        end
        lo = (a ^ b) & N'((1 << k) - 1);
        if (pos >= 0) lo = lo | N'((1 << (pos + 1)) - 1);
        approx = up | {1'b0, lo};
        exact  = {1'b0, a} + {1'b0, b};
        r.s = approx[N-1:0];
        r.c = approx[N];
        r.e = (exact > approx) ? exact - approx : approx - exact;
        return r;
    endfunction

    // One clock of stimulus. Inputs are applied at negedge and outputs sampled 1 time unit later.
    // The task predicts the handshakes of the coming posedge and keeps the reference queue and statistics.
    task automatic drive_cycle(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [KW-1:0] k, input logic ex, input logic ordy, input logic clr,
                               output logic acc, output logic took, output logic exp_ok,
                               output res_t obs, output res_t expv, output logic ov, output logic ir);
        @(negedge clk);
        bus.in_valid  = v;
        bus.x         = a;
        bus.y         = b;
        bus.k_sel     = k;
        bus.exact_en  = ex;
        bus.out_ready = ordy;
        stats_clr     = clr;
        #1;
        ir     = bus.in_ready;
        ov     = bus.out_valid;
        obs.s  = bus.s;
        obs.c  = bus.cout;
        obs.e  = bus.err_mag;
        acc    = v && ir;
        took   = ov && ordy;
        exp_ok = 1'b0;
        expv.s = '0;
        expv.c = 1'b0;
        expv.e = '0;
        if (took && exp_q.size() > 0) begin
            expv   = exp_q.pop_front();
            exp_ok = 1'b1;
        end
        if (acc) exp_q.push_back(ref_model(a, b, k, ex));
        if (clr) begin
            m_op = 0; m_err = 0; m_max = '0;
        end else if (took && exp_ok) begin
            if (m_op < (1 << CW) - 1) m_op++;
            if (expv.e != 0 && m_err < (1 << CW) - 1) m_err++;
            if (expv.e > m_max) m_max = expv.e;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stats_clr = 1'b0;
        bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.k_sel = '0; bus.exact_en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_op = 0; m_err = 0; m_max = '0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        checks++; if (bus.s !== 16'h0000 || bus.cout !== 1'b0 || bus.err_mag !== 17'h0) begin
            errors++; $display("FAIL reset_result got s=%h c=%b e=%h want 0", bus.s, bus.cout, bus.err_mag); end
        checks++; if (op_cnt !== 16'h0 || err_cnt !== 16'h0 || max_err !== 17'h0) begin
            errors++; $display("FAIL reset_stats got %h %h %h want 0", op_cnt, err_cnt, max_err); end
    endtask

    task automatic test_directed();
        logic [N-1:0]  vx[7] = '{16'h0800, 16'h0800, 16'h00FF, 16'h00FF, 16'hFFFF, 16'h5555, 16'h00FF};
        logic [N-1:0]  vy[7] = '{16'h0801, 16'h0801, 16'h00FF, 16'h00FF, 16'hFFFF, 16'hAAAA, 16'h00FF};
        logic [KW-1:0] vk[7] = '{4'd12, 4'd12, 4'd12, 4'd4, 4'd12, 4'd12, 4'd15};
        logic          vex[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [N-1:0]  vs[7] = '{16'h0FFF, 16'h1001, 16'h00FF, 16'h01EF, 16'hEFFF, 16'hFFFF, 16'h00FF};
        logic          vc[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [N:0]    ve[7] = '{17'h2, 17'h0, 17'hFF, 17'hF, 17'hFFF, 17'h0, 17'hFF};
        logic acc, took, exp_ok, ov, ir, pend, got;
        res_t obs, expv;
        int acc_cyc;
        for (int b = 0; b < 7; b++) begin
            pend = 1'b1; got = 1'b0; acc_cyc = -1;
            for (int c = 0; c < 10 && !got; c++) begin
                drive_cycle(pend, vx[b], vy[b], vk[b], vex[b], 1'b1, 1'b0, acc, took, exp_ok, obs, expv, ov, ir);
                if (acc) begin pend = 1'b0; acc_cyc = c; end
                if (took) begin
                    got = 1'b1;
                    checks++; if (obs.s !== vs[b] || obs.c !== vc[b] || obs.e !== ve[b]) begin
                        errors++; $display("FAIL directed_%0d got s=%h c=%b e=%h want s=%h c=%b e=%h",
                                           b, obs.s, obs.c, obs.e, vs[b], vc[b], ve[b]); end
                    checks++; if (!exp_ok || obs.s !== expv.s || obs.c !== expv.c || obs.e !== expv.e) begin
                        errors++; $display("FAIL directed_model_%0d got s=%h c=%b e=%h want s=%h c=%b e=%h",
                                           b, obs.s, obs.c, obs.e, expv.s, expv.c, expv.e); end
                    checks++; if (c - acc_cyc != 2) begin
                        errors++; $display("FAIL latency_%0d got %0d want 2", b, c - acc_cyc); end
                end
            end
            if (!got) begin checks++; errors++; $display("FAIL directed_timeout_%0d got none want result", b); end
            drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, acc, took, exp_ok, obs, expv, ov, ir);
            if (b == 5) begin
                checks++; if (op_cnt !== 16'd6 || err_cnt !== 16'd4 || max_err !== 17'hFFF) begin
                    errors++; $display("FAIL stats_after_6 got op=%0d err=%0d max=%h want 6 4 fff", op_cnt, err_cnt, max_err); end
            end
        end
    endtask

    task automatic test_stats_clear();
        logic acc, took, exp_ok, ov, ir;
        res_t obs, expv;
        int c;
        drive_cycle(1'b1, 16'h00FF, 16'h00FF, 4'd12, 1'b0, 1'b0, 1'b0, acc, took, exp_ok, obs, expv, ov, ir);
        ov = 1'b0;
        for (c = 0; c < 8 && !ov; c++)
            drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, acc, took, exp_ok, obs, expv, ov, ir);
        checks++; if (op_cnt === 16'h0) begin errors++; $display("FAIL clr_precond got op=%0d want nonzero", op_cnt); end
        drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, acc, took, exp_ok, obs, expv, ov, ir);
        checks++; if (took !== 1'b1) begin errors++; $display("FAIL clr_handshake got %0b want 1", took); end
        drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, acc, took, exp_ok, obs, expv, ov, ir);
        checks++; if (op_cnt !== 16'h0 || err_cnt !== 16'h0 || max_err !== 17'h0) begin
            errors++; $display("FAIL clr_stats got %h %h %h want 0", op_cnt, err_cnt, max_err); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL clr_beat_consumed got out_valid=%0b want 0", ov); end
    endtask

    // Shared loop body of the streaming tests: in-order results, stall stability and the in_ready rule.
    task automatic stream(input int beats, input int max_cyc, input logic toggle, input logic rnd_clr, input string tag);
        logic acc, took, exp_ok, ov, ir, ordy, clr, cv, cex, prev_stall;
        logic [N-1:0] cx, cy;
        logic [KW-1:0] ck;
        res_t obs, expv, prev_obs;
        int sent, taken, qs;
        sent = 0; taken = 0; prev_stall = 1'b0;
        cv = 1'b1; cx = N'($urandom); cy = N'($urandom); ck = KW'($urandom_range(0, 15)); cex = ($urandom_range(0, 7) == 0);
        prev_obs.s = '0; prev_obs.c = 1'b0; prev_obs.e = '0;
        for (int c = 0; c < max_cyc && taken < beats; c++) begin
            ordy = toggle ? ((c % 2) == 0) : ($urandom_range(0, 9) < 7);
            clr  = rnd_clr && ($urandom_range(0, 49) == 0);
            qs = exp_q.size();
            drive_cycle(cv && sent < beats, cx, cy, ck, cex, ordy, clr, acc, took, exp_ok, obs, expv, ov, ir);
            checks++; if (ir !== !(qs == 2 && !ordy)) begin
                errors++; $display("FAIL %s_in_ready cyc %0d got %0b want %0b", tag, c, ir, !(qs == 2 && !ordy)); end
            if (prev_stall) begin
                checks++; if (ov !== 1'b1 || obs.s !== prev_obs.s || obs.c !== prev_obs.c || obs.e !== prev_obs.e) begin
                    errors++; $display("FAIL %s_stall_hold cyc %0d got v=%0b s=%h e=%h want v=1 s=%h e=%h",
                                       tag, c, ov, obs.s, obs.e, prev_obs.s, prev_obs.e); end
            end
            if (took) begin
                taken++;
                checks++; if (!exp_ok || obs.s !== expv.s || obs.c !== expv.c || obs.e !== expv.e) begin
                    errors++; $display("FAIL %s_result cyc %0d got s=%h c=%b e=%h want s=%h c=%b e=%h ok=%0b",
                                       tag, c, obs.s, obs.c, obs.e, expv.s, expv.c, expv.e, exp_ok); end
            end
            if (acc) begin
                sent++;
                cx = N'($urandom); cy = N'($urandom); ck = KW'($urandom_range(0, 15)); cex = ($urandom_range(0, 7) == 0);
                cv = toggle ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else if (!cv) begin
                cv = ($urandom_range(0, 3) != 0);
            end
            prev_stall = ov && !ordy;
            prev_obs = obs;
        end
        checks++; if (taken != beats || exp_q.size() != 0) begin
            errors++; $display("FAIL %s_count got %0d taken %0d queued want %0d taken 0 queued", tag, taken, exp_q.size(), beats); end
    endtask

    task automatic test_back_to_back();
        stream(6, 60, 1'b1, 1'b0, "b2b");
    endtask

    task automatic test_random();
        logic acc, took, exp_ok, ov, ir;
        res_t obs, expv;
        drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc, took, exp_ok, obs, expv, ov, ir);
        stream(150, 2000, 1'b0, 1'b1, "rnd");
        drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, acc, took, exp_ok, obs, expv, ov, ir);
        checks++; if (op_cnt !== CW'(m_op) || err_cnt !== CW'(m_err) || max_err !== m_max) begin
            errors++; $display("FAIL rnd_stats got op=%0d err=%0d max=%h want op=%0d err=%0d max=%h",
                               op_cnt, err_cnt, max_err, m_op, m_err, m_max); end
    endtask

    task automatic test_reset_midflight();
        logic acc, took, exp_ok, ov, ir;
        res_t obs, expv;
        int sent;
        sent = 0;
        for (int c = 0; c < 10 && sent < 2; c++) begin
            drive_cycle(1'b1, N'($urandom), N'($urandom), 4'd12, 1'b0, 1'b0, 1'b0, acc, took, exp_ok, obs, expv, ov, ir);
            if (acc) sent++;
        end
        checks++; if (sent != 2) begin errors++; $display("FAIL midrst_fill got %0d want 2", sent); end
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.delete();
        m_op = 0; m_err = 0; m_max = '0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_state got v=%0b r=%0b want v=0 r=1", bus.out_valid, bus.in_ready); end
        checks++; if (op_cnt !== 16'h0 || err_cnt !== 16'h0 || max_err !== 17'h0) begin
            errors++; $display("FAIL midrst_stats got %h %h %h want 0", op_cnt, err_cnt, max_err); end
        for (int c = 0; c < 8; c++) begin
            drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, acc, took, exp_ok, obs, expv, ov, ir);
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL midrst_stale cyc %0d got out_valid=1 want 0", c); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_stats_clear();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
